// File: rtl/spi_slave_mode.sv
// rtl/spi_slave_mode.sv - SPI slave (CPOL/CPHA) with opcode parser, rx/tx byte FIFOs and AXI-Stream sides
// Define SPI_LOOPBACK_EN to add opcode 0x10, which echoes each slot's byte back in the following slot.
module spi_slave_mode #(
   parameter int         CPOL        = 0,
   parameter int         CPHA        = 0,
   parameter int         FIFO_DEPTH  = 16,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] FILL_BYTE   = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sck,
   input  logic       ssel_n,
   input  logic       mosi,
   output logic       miso,
   output logic       spi_reset,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   output logic       rx_overflow,
   output logic       tx_underflow,
   output logic       busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic SCK_IDLE = 1'(CPOL);
   localparam bit SAMPLE_ON_RISE = (CPOL == CPHA);

   typedef enum logic [2:0] {IDLE, STAT0, STAT1, STAT2, READ, WRITE, WRITE_READ, LOOP} state_e;

   logic [SYNC_STAGES-1:0] sck_sync_q, ssel_sync_q, mosi_sync_q;
   logic sck_prev_q, ssel_prev_q;
   logic sck_s, ssel_s, mosi_s, sck_rise, sck_fall, sample_edge, shift_edge;
   logic sel_active, sel_start, byte_ev;
   logic [2:0] bit_cnt_q;
   logic       byte_rx_q;
   logic [7:0] rx_shift_q, tx_shift_q, next_tx_q, load_byte;
   state_e     state_q, state_d;
   logic       first_q, rx_ovf_q, tx_unf_q, spi_reset_q;
   logic       tx_slot, rx_wr_req, flush, clr_flags;

   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] rx_wptr_q, rx_rptr_q;
   logic [CW-1:0] rx_cnt_q, rx_free;
   logic          rx_full, rx_empty, rx_push, rx_pop;
   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [AW-1:0] tx_wptr_q, tx_rptr_q;
   logic [CW-1:0] tx_cnt_q;
   logic          tx_full, tx_empty, tx_push, tx_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         sck_sync_q  <= {SYNC_STAGES{SCK_IDLE}};
         ssel_sync_q <= {SYNC_STAGES{1'b1}};
         mosi_sync_q <= '0;
         sck_prev_q  <= SCK_IDLE;
         ssel_prev_q <= 1'b1;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
         ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], ssel_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sck_prev_q  <= sck_s;
         ssel_prev_q <= ssel_s;
      end
   end

   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign ssel_s      = ssel_sync_q[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_prev_q;
   assign sck_fall    = ~sck_s & sck_prev_q;
   assign sample_edge = SAMPLE_ON_RISE ? sck_rise : sck_fall;
   assign shift_edge  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
   assign sel_active  = ~ssel_s;
   assign sel_start   = ~ssel_s & ssel_prev_q;
   assign byte_ev     = byte_rx_q & sel_active;
   assign busy        = sel_active;

   always_ff @(posedge clk) begin
      if (reset || !sel_active) begin
         bit_cnt_q  <= 3'd0;
         byte_rx_q  <= 1'b0;
         rx_shift_q <= rx_shift_q;
      end else begin
         byte_rx_q <= sample_edge && (bit_cnt_q == 3'd7);
         if (sample_edge) begin
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            rx_shift_q <= {rx_shift_q[6:0], mosi_s};
         end
      end
   end

   // A shift edge seen at bit 0 is a byte boundary for both CPHA settings: load instead of shift.
   always_ff @(posedge clk) begin
      if (reset)
         tx_shift_q <= 8'h00;
      else if (sel_start)
         tx_shift_q <= FILL_BYTE;
      else if (sel_active && shift_edge)
         tx_shift_q <= (bit_cnt_q == 3'd0) ? next_tx_q : {tx_shift_q[6:0], 1'b0};
   end
   assign miso = tx_shift_q[7];

   assign rx_full  = (rx_cnt_q == DEPTH_C);
   assign rx_empty = (rx_cnt_q == '0);
   assign rx_free  = DEPTH_C - rx_cnt_q;
   assign rx_push  = rx_wr_req & ~rx_full;
   assign rx_pop   = ~rx_empty & m_axis_tready;
   assign m_axis_tvalid = ~rx_empty;
   assign m_axis_tdata  = rx_mem_q[rx_rptr_q];

   assign tx_full  = (tx_cnt_q == DEPTH_C);
   assign tx_empty = (tx_cnt_q == '0);
   assign s_axis_tready = ~reset & ~tx_full;
   assign tx_push  = s_axis_tvalid & s_axis_tready;
   assign tx_pop   = tx_slot & ~tx_empty;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_shift_q;
      if (tx_push) tx_mem_q[tx_wptr_q] <= s_axis_tdata;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rx_wptr_q <= '0;
         rx_rptr_q <= '0;
         rx_cnt_q  <= '0;
         tx_wptr_q <= '0;
         tx_rptr_q <= '0;
         tx_cnt_q  <= '0;
      end else begin
         if (rx_push) rx_wptr_q <= rx_wptr_q + AW'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + AW'(1);
         if (rx_push && !rx_pop) rx_cnt_q <= rx_cnt_q + CW'(1);
         else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CW'(1);
         if (tx_push) tx_wptr_q <= tx_wptr_q + AW'(1);
         if (tx_pop)  tx_rptr_q <= tx_rptr_q + AW'(1);
         if (tx_push && !tx_pop) tx_cnt_q <= tx_cnt_q + CW'(1);
         else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CW'(1);
      end
   end

   // load_byte is what the next byte slot will shift out; opcodes are only decoded in the first slot.
   always_comb begin
      state_d   = state_q;
      tx_slot   = 1'b0;
      rx_wr_req = 1'b0;
      flush     = 1'b0;
      clr_flags = 1'b0;
      load_byte = FILL_BYTE;
      if (byte_ev) begin
         if (first_q) begin
            case (rx_shift_q)
               8'h81: begin state_d = STAT0; load_byte = 8'(rx_free); end
               8'h82: begin state_d = READ; tx_slot = 1'b1; end
               8'h04: state_d = WRITE;
               8'h86: begin state_d = WRITE_READ; tx_slot = 1'b1; end
               8'h08: flush = 1'b1;
`ifdef SPI_LOOPBACK_EN
               8'h10: begin state_d = LOOP; load_byte = rx_shift_q; end
`endif
               default: ;
            endcase
         end else begin
            case (state_q)
               STAT0:      begin state_d = STAT1; load_byte = 8'(tx_cnt_q); end
               STAT1:      begin state_d = STAT2; load_byte = {6'b0, rx_ovf_q, tx_unf_q}; clr_flags = 1'b1; end
               STAT2:      state_d = IDLE;
               READ:       tx_slot = 1'b1;
               WRITE:      rx_wr_req = 1'b1;
               WRITE_READ: begin tx_slot = 1'b1; rx_wr_req = 1'b1; end
               LOOP:       load_byte = rx_shift_q;
               default: ;
            endcase
         end
      end
      if (tx_slot) load_byte = tx_empty ? FILL_BYTE : tx_mem_q[tx_rptr_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         first_q     <= 1'b1;
         next_tx_q   <= FILL_BYTE;
         rx_ovf_q    <= 1'b0;
         tx_unf_q    <= 1'b0;
         spi_reset_q <= 1'b0;
      end else begin
         spi_reset_q <= flush;
         if (flush || clr_flags) begin
            rx_ovf_q <= 1'b0;
            tx_unf_q <= 1'b0;
         end else begin
            if (rx_wr_req && rx_full) rx_ovf_q <= 1'b1;
            if (tx_slot && tx_empty)  tx_unf_q <= 1'b1;
         end
         if (!sel_active) begin
            state_q <= IDLE;
            first_q <= 1'b1;
         end else if (byte_ev) begin
            state_q <= state_d;
            first_q <= 1'b0;
         end
         if (sel_start)
            next_tx_q <= FILL_BYTE;
         else if (byte_ev)
            next_tx_q <= load_byte;
      end
   end

   assign spi_reset    = spi_reset_q;
   assign rx_overflow  = rx_ovf_q;
   assign tx_underflow = tx_unf_q;
endmodule

// File: tb/tb_spi_slave_mode.sv
// tb/tb_spi_slave_mode.sv - directed bench; one DUT per SPI mode (index = {CPOL, CPHA}), mode 0 carries most scenarios
module tb_spi_slave_mode;
   localparam int HALF = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [3:0] sck_v;
   logic       ssel_n, mosi, m_tready, s_tvalid;
   logic [7:0] s_tdata;
   logic       miso_w [4];
   logic       spi_reset_w [4];
   logic       m_tvalid_w [4];
   logic       s_tready_w [4];
   logic       ovf_w [4];
   logic       unf_w [4];
   logic       busy_w [4];
   logic [7:0] m_tdata_w [4];

   int n_tests = 0;
   int n_fail = 0;
   int rst_pulses = 0;
   logic [7:0] cap_q [$];
   logic [7:0] tx_buf [20];
   logic [7:0] rx_buf [20];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_slave_mode #(.CPOL(g / 2), .CPHA(g % 2), .FIFO_DEPTH(16), .SYNC_STAGES(2), .FILL_BYTE(8'h00)) u_dut (
         .clk(clk), .reset(reset), .sck(sck_v[g]), .ssel_n(ssel_n), .mosi(mosi),
         .miso(miso_w[g]), .spi_reset(spi_reset_w[g]),
         .m_axis_tdata(m_tdata_w[g]), .m_axis_tvalid(m_tvalid_w[g]), .m_axis_tready(m_tready),
         .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_w[g]),
         .rx_overflow(ovf_w[g]), .tx_underflow(unf_w[g]), .busy(busy_w[g])
      );
   end

   always @(negedge clk) begin
      for (int k = 0; k < 4; k++)
         if (m_tvalid_w[k] && m_tready) cap_q.push_back(m_tdata_w[k]);
      if (spi_reset_w[0]) rst_pulses++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input int m, input logic [7:0] tx, input int nb, output logic [7:0] rx);
      logic lead;
      lead = (m >= 2) ? 1'b0 : 1'b1;
      rx = 8'h00;
      for (int i = 7; i > 7 - nb; i--) begin
         if (m % 2 == 0) begin
            mosi = tx[i]; tick(HALF);
            sck_v[m] = lead; rx[i] = miso_w[m]; tick(HALF);
            sck_v[m] = ~lead;
         end else begin
            sck_v[m] = lead; mosi = tx[i]; tick(HALF);
            sck_v[m] = ~lead; rx[i] = miso_w[m]; tick(HALF);
         end
      end
   endtask

   task automatic txn(input int m, input int n);
      logic [7:0] r;
      ssel_n = 1'b0; tick(8);
      for (int b = 0; b < n; b++) begin
         spi_bits(m, tx_buf[b], 8, r);
         rx_buf[b] = r;
      end
      tick(8); ssel_n = 1'b1; tick(8);
   endtask

   task automatic axis_push(input logic [7:0] b);
      int w;
      w = 0;
      s_tdata = b; s_tvalid = 1'b1;
      while (!s_tready_w[0] && w < 50) begin tick(1); w++; end
      tick(1); s_tvalid = 1'b0;
      n_tests++;
      if (w >= 50) begin n_fail++; $display("FAIL axis_push: tready wait %0d cycles, required < 50", w); end
   endtask

   task automatic test_reset;
      reset = 1'b1; sck_v = 4'b1100; ssel_n = 1'b1; mosi = 1'b0;
      m_tready = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00;
      tick(4);
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if ({miso_w[k], spi_reset_w[k], m_tvalid_w[k], s_tready_w[k], ovf_w[k], unf_w[k], busy_w[k]} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got %b, required 0000000", k,
                     {miso_w[k], spi_reset_w[k], m_tvalid_w[k], s_tready_w[k], ovf_w[k], unf_w[k], busy_w[k]});
         end
      end
      reset = 1'b0; tick(4);
      n_tests++;
      if (s_tready_w[0] !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b, required 1", s_tready_w[0]); end
   endtask

   task automatic test_write;
      m_tready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         ssel_n = 1'b0; tick(6);
         n_tests++;
         if (busy_w[m] !== 1'b1) begin n_fail++; $display("FAIL busy_on[%0d]: got %b, required 1", m, busy_w[m]); end
         ssel_n = 1'b1; tick(6);
         n_tests++;
         if (busy_w[m] !== 1'b0) begin n_fail++; $display("FAIL busy_off[%0d]: got %b, required 0", m, busy_w[m]); end
         cap_q.delete();
         tx_buf[0] = 8'h04; tx_buf[1] = 8'hA5; tx_buf[2] = 8'h3C;
         txn(m, 3); tick(10);
         n_tests++;
         if (cap_q.size() !== 2) begin n_fail++; $display("FAIL write_count[%0d]: got %0d, required 2", m, cap_q.size()); end
         else begin
            n_tests++;
            if (cap_q[0] !== 8'hA5) begin n_fail++; $display("FAIL write_b0[%0d]: got %02h, required a5", m, cap_q[0]); end
            n_tests++;
            if (cap_q[1] !== 8'h3C) begin n_fail++; $display("FAIL write_b1[%0d]: got %02h, required 3c", m, cap_q[1]); end
         end
         n_tests++;
         if (ovf_w[m] !== 1'b0) begin n_fail++; $display("FAIL write_ovf[%0d]: got %b, required 0", m, ovf_w[m]); end
      end
   endtask

   task automatic test_read;
      logic [7:0] e [4];
      axis_push(8'h11); axis_push(8'h22);
      tx_buf[0] = 8'h82; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(0, 4);
      e = '{8'h00, 8'h11, 8'h22, 8'h00};
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL read_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
      n_tests++;
      if (unf_w[0] !== 1'b1) begin n_fail++; $display("FAIL read_underflow: got %b, required 1", unf_w[0]); end
      // status readout right after also clears the underflow flag
      tx_buf[0] = 8'h81;
      txn(0, 4);
      e = '{8'h00, 8'h10, 8'h00, 8'h01};
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL stat_a_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
      n_tests++;
      if (unf_w[0] !== 1'b0) begin n_fail++; $display("FAIL underflow_cleared: got %b, required 0", unf_w[0]); end
   endtask

   task automatic test_status;
      logic [7:0] e [4];
      axis_push(8'h31); axis_push(8'h32); axis_push(8'h33);
      m_tready = 1'b0;
      tx_buf[0] = 8'h04;
      for (int i = 1; i <= 16; i++) tx_buf[i] = 8'(i);
      txn(0, 17);
      n_tests++;
      if (ovf_w[0] !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b, required 0", ovf_w[0]); end
      tx_buf[0] = 8'h04; tx_buf[1] = 8'hEE;
      txn(0, 2);
      n_tests++;
      if (ovf_w[0] !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b, required 1", ovf_w[0]); end
      tx_buf[0] = 8'h81; tx_buf[1] = 8'h00;
      txn(0, 4);
      e = '{8'h00, 8'h00, 8'h03, 8'h02};
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL stat_b_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
      n_tests++;
      if ({ovf_w[0], unf_w[0]} !== 2'b00) begin n_fail++; $display("FAIL flags_after_stat: got %b, required 00", {ovf_w[0], unf_w[0]}); end
      cap_q.delete(); m_tready = 1'b1; tick(40);
      n_tests++;
      if (cap_q.size() !== 16) begin n_fail++; $display("FAIL drain_count: got %0d, required 16", cap_q.size()); end
      else begin
         n_tests++;
         if (cap_q[0] !== 8'h01 || cap_q[15] !== 8'h10) begin
            n_fail++; $display("FAIL drain_data: got %02h..%02h, required 01..10", cap_q[0], cap_q[15]);
         end
      end
   endtask

   task automatic test_abort;
      logic [7:0] r;
      logic [7:0] e [4];
      cap_q.delete();
      ssel_n = 1'b0; tick(8);
      spi_bits(0, 8'h04, 8, r);
      spi_bits(0, 8'hFF, 5, r);
      tick(4); ssel_n = 1'b1; tick(12);
      n_tests++;
      if (cap_q.size() !== 0 || m_tvalid_w[0] !== 1'b0) begin
         n_fail++; $display("FAIL abort_push: got %0d bytes valid=%b, required 0 bytes valid=0", cap_q.size(), m_tvalid_w[0]);
      end
      tx_buf[0] = 8'h81; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(0, 4);
      e = '{8'h00, 8'h10, 8'h03, 8'h00};
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL abort_stat_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
   endtask

   task automatic test_reset_cmd;
      logic [7:0] e [4];
      axis_push(8'h34);
      m_tready = 1'b0;
      tx_buf[0] = 8'h04; tx_buf[1] = 8'hA1; tx_buf[2] = 8'hA2; tx_buf[3] = 8'hA3; tx_buf[4] = 8'hA4;
      txn(0, 5);
      n_tests++;
      if (m_tvalid_w[0] !== 1'b1) begin n_fail++; $display("FAIL pre_flush_valid: got %b, required 1", m_tvalid_w[0]); end
      rst_pulses = 0;
      tx_buf[0] = 8'h08;
      txn(0, 1);
      n_tests++;
      if (rst_pulses !== 1) begin n_fail++; $display("FAIL spi_reset_width: got %0d cycles, required 1", rst_pulses); end
      n_tests++;
      if (m_tvalid_w[0] !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", m_tvalid_w[0]); end
      tx_buf[0] = 8'h81; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(0, 4);
      e = '{8'h00, 8'h10, 8'h00, 8'h00};
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL flush_stat_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
   endtask

   task automatic test_loopback;
      logic [7:0] e [4];
      m_tready = 1'b1; cap_q.delete();
      tx_buf[0] = 8'h10; tx_buf[1] = 8'h5A; tx_buf[2] = 8'hC3;
      txn(0, 3);
`ifdef SPI_LOOPBACK_EN
      e = '{8'h00, 8'h10, 8'h5A, 8'h00};
`else
      e = '{8'h00, 8'h00, 8'h00, 8'h00};
`endif
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL loop_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
      tx_buf[0] = 8'h55; tx_buf[1] = 8'h81; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
      txn(0, 4);
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (rx_buf[i] !== 8'h00) begin n_fail++; $display("FAIL unknown_slot%0d: got %02h, required 00", i, rx_buf[i]); end
      end
      n_tests++;
      if (cap_q.size() !== 0) begin n_fail++; $display("FAIL unknown_no_push: got %0d bytes, required 0", cap_q.size()); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] e [3];
      // mode-3 DUT still holds 11,22,31,32,33,34 from earlier fabric pushes
      m_tready = 1'b1; cap_q.delete();
      tx_buf[0] = 8'h86; tx_buf[1] = 8'hD1; tx_buf[2] = 8'hD2;
      txn(3, 3); tick(10);
      e = '{8'h00, 8'h11, 8'h22};
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (rx_buf[i] !== e[i]) begin n_fail++; $display("FAIL wr_rd_slot%0d: got %02h, required %02h", i, rx_buf[i], e[i]); end
      end
      n_tests++;
      if (cap_q.size() !== 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d, required 2", cap_q.size()); end
      else begin
         n_tests++;
         if (cap_q[0] !== 8'hD1 || cap_q[1] !== 8'hD2) begin
            n_fail++; $display("FAIL wr_rd_data: got %02h %02h, required d1 d2", cap_q[0], cap_q[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_status();
      test_abort();
      test_reset_cmd();
      test_loopback();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required bench completion");
      $fatal(1);
   end
endmodule
